pixel_compositor: RTL and testbench

- Parametrised successor to the fixed four-source OR-to-white pixel mux in the pong top level.
- Merges NUM_LAYERS sprite "pixel_valid" streams (ball, paddles, background, score, ...) into one RGB pixel, using fixed priority, a per-layer colour and a runtime layer-enable mask.
- Adds a blanking-aware, 2-stage pipelined output and a per-frame collision detector (layer 0 = ball vs every other layer), snapshotted at vblank for the game logic.
- Sits between the sprite generators and the VGA pins, in the pixel clock-enable domain.

---
 rtl/pixel_compositor.sv | 85 ++++++++
 tb/tb_pixel_compositor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// Layered sprite compositor: fixed-priority colour merge with a 2-stage pixel pipeline
// and a per-frame ball-vs-layer collision detector latched at the vblank rising edge.
module pixel_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W = 8,
  parameter logic [NUM_LAYERS*COLOR_W-1:0] LAYER_COLORS = {NUM_LAYERS{{COLOR_W{1'b1}}}},
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [NUM_LAYERS-1:0] layer_valid,
  input  logic [NUM_LAYERS-1:0] layer_en,
  input  logic                  blank,
  input  logic                  vblank,
  output logic [COLOR_W-1:0]    rgb_out,
  output logic                  de_out,
  output logic [NUM_LAYERS-2:0] collision,
  output logic                  collision_stb
);

  logic [NUM_LAYERS-1:0] m_s1;
  logic                  blank_s1;
  logic                  vblank_s1;
  logic                  vblank_q;
  logic [NUM_LAYERS-2:0] acc;
  logic [NUM_LAYERS-2:0] hit;
  logic [COLOR_W-1:0]    pix_color;
  logic                  vblank_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1      <= '0;
      blank_s1  <= 1'b0;
      vblank_s1 <= 1'b0;
    end else if (pix_en) begin
      m_s1      <= layer_valid & layer_en;
      blank_s1  <= blank;
      vblank_s1 <= vblank;
    end
  end

  // Scan from lowest priority upward so the lowest set index wins.
  always_comb begin
    pix_color = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (m_s1[k]) pix_color = LAYER_COLORS[k*COLOR_W +: COLOR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out <= '0;
      de_out  <= 1'b0;
    end else if (pix_en) begin
      rgb_out <= blank_s1 ? '0 : pix_color;
      de_out  <= ~blank_s1;
    end
  end

  assign hit         = (!blank_s1 && m_s1[0]) ? m_s1[NUM_LAYERS-1:1] : '0;
  assign vblank_rise = vblank_s1 & ~vblank_q;

  // The boundary cycle folds in its own hit so an overlap on that pixel is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      collision     <= '0;
      vblank_q      <= 1'b0;
      collision_stb <= 1'b0;
    end else begin
      collision_stb <= pix_en & vblank_rise;
      if (pix_en) begin
        vblank_q <= vblank_s1;
        if (vblank_rise) begin
          collision <= acc | hit;
          acc       <= '0;
        end else begin
          acc <= acc | hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Scoreboard bench for pixel_compositor: expected pixels and collision results are
// queued per pix_en beat and compared when they emerge two beats later.
module tb_pixel_compositor;

  localparam int NL = 4;
  localparam int CW = 8;
  localparam logic [NL*CW-1:0] COLORS = {8'h03, 8'h1C, 8'hE0, 8'hFF};
  localparam logic [CW-1:0]    BG     = 8'h00;

  logic          clk;
  logic          rst_n;
  logic          pix_en;
  logic [NL-1:0] layer_valid;
  logic [NL-1:0] layer_en;
  logic          blank;
  logic          vblank;
  logic [CW-1:0] rgb_out;
  logic          de_out;
  logic [NL-2:0] collision;
  logic          collision_stb;

  typedef struct {
    logic [CW-1:0] rgb;
    logic          de;
    logic          rise;
    logic [NL-2:0] coll;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [NL-2:0] model_acc;
  logic [NL-2:0] model_coll;
  logic          prev_vb;

  pixel_compositor #(
    .NUM_LAYERS(NL),
    .COLOR_W(CW),
    .LAYER_COLORS(COLORS),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_en(pix_en),
    .layer_valid(layer_valid),
    .layer_en(layer_en),
    .blank(blank),
    .vblank(vblank),
    .rgb_out(rgb_out),
    .de_out(de_out),
    .collision(collision),
    .collision_stb(collision_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    model_acc  = '0;
    model_coll = '0;
    prev_vb    = 1'b0;
  endtask

  // One pix_en beat; gap=1 adds an idle clk with pix_en low to check output hold.
  task automatic applyStimulus(input logic [NL-1:0] valid, input logic [NL-1:0] en,
                               input logic blank_i, input logic vblank_i, input bit gap);
    exp_t          e;
    exp_t          got;
    logic [NL-1:0] m;
    logic [NL-2:0] h;
    bit            popped;
    layer_valid = valid;
    layer_en    = en;
    blank       = blank_i;
    vblank      = vblank_i;
    m = valid & en;
    e.rgb = BG;
    for (int k = 0; k < NL; k++) begin
      if (m[k]) begin
        e.rgb = COLORS[k*CW +: CW];
        break;
      end
    end
    if (blank_i) e.rgb = '0;
    e.de = ~blank_i;
    h = (!blank_i && m[0]) ? m[NL-1:1] : '0;
    e.rise = vblank_i & ~prev_vb;
    if (e.rise) begin
      model_coll = model_acc | h;
      model_acc  = '0;
    end else begin
      model_acc = model_acc | h;
    end
    e.coll  = model_coll;
    prev_vb = vblank_i;
    sb.push_back(e);

    pix_en = 1'b1;
    @(posedge clk);
    #1;
    popped = 1'b0;
    if (sb.size() > 1) begin
      got = sb.pop_front();
      popped = 1'b1;
      checkOutput("rgb", 32'(rgb_out), 32'(got.rgb));
      checkOutput("de", 32'(de_out), 32'(got.de));
      checkOutput("stb", 32'(collision_stb), 32'(got.rise));
      checkOutput("collision", 32'(collision), 32'(got.coll));
    end
    if (gap) begin
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      if (popped) begin
        checkOutput("rgb_hold", 32'(rgb_out), 32'(got.rgb));
        checkOutput("de_hold", 32'(de_out), 32'(got.de));
        checkOutput("stb_gap", 32'(collision_stb), 32'(0));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_en = 1'b0;
    layer_valid = '0;
    layer_en = '0;
    blank = 1'b0;
    vblank = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rgb", 32'(rgb_out), 32'(0));
    checkOutput("reset_de", 32'(de_out), 32'(0));
    checkOutput("reset_coll", 32'(collision), 32'(0));
    checkOutput("reset_stb", 32'(collision_stb), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Priority and background
    applyStimulus(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0);
    // Masking
    applyStimulus(4'b0011, 4'b1110, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0111, 4'b1100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0);
    // Blanking
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    // pix_en at half rate
    applyStimulus(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0);

    // Frame 1: three ball/layer-2 overlaps, one blanked ball/layer-1 overlap
    for (int i = 0; i < 3; i++) applyStimulus(4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    // Frame 2: no overlap
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1110, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 4'b0111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    // Coincident hit on the boundary pixel
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 4'b1111, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    // Accumulator must be empty after the boundary
    for (int i = 0; i < 3; i++) applyStimulus(4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    // Accumulate hits, then reset asynchronously mid-frame
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    pix_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rgb", 32'(rgb_out), 32'(0));
    checkOutput("async_de", 32'(de_out), 32'(0));
    checkOutput("async_coll", 32'(collision), 32'(0));
    checkOutput("async_stb", 32'(collision_stb), 32'(0));
    #10;
    rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    // Full-rate overlap with runtime enable change
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b1011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b1001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
